// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch queue between fetch and decode.
// This is a small circular buffer of (pc, inst) pairs. Occupancy is tracked
// by an explicit count, so full and empty never have to be inferred from the
// pointers alone. in_ready looks only at count, which keeps decode's
// out_ready off the combinational path back into the fetch stage.
module inst_prefetch_queue #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [31:0]      in_pc,
    input  logic [31:0]      in_inst,
    output logic             in_ready,
    output logic             out_valid,
    output logic [31:0]      out_pc,
    output logic [31:0]      out_inst,
    input  logic             out_ready,
    output logic [PTR_W:0]   count
);

    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

    logic [31:0]      pc_mem   [DEPTH];
    logic [31:0]      inst_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push;
    logic             pop;

    // Handshakes use only registered occupancy, and a flush cancels both of them
    always_comb begin
        in_ready  = (count != FULL_COUNT);
        out_valid = (count != '0);
        push      = in_valid && in_ready && !flush;
        pop       = out_valid && out_ready && !flush;
    end

    // The head entry is shown directly from storage, and it reads as zero whenever the queue is empty
    always_comb begin
        out_pc   = 32'h0;
        out_inst = 32'h0;
        if (out_valid) begin
            out_pc   = pc_mem[rd_ptr];
            out_inst = inst_mem[rd_ptr];
        end
    end

    // Storage is never cleared; count alone decides which entries are live
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]   <= in_pc;
            inst_mem[wr_ptr] <= in_inst;
        end
    end

    // Pointer and occupancy update; reset outranks flush, and flush outranks traffic
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Directed testbench for inst_prefetch_queue (DEPTH=4).
// Inputs change 1ns after each rising edge, and outputs are sampled at that same point.
module tb_inst_prefetch_queue;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_pc;
    logic [31:0] in_inst;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_ready;
    logic [2:0]  count;

    int total;
    int bad;

    inst_prefetch_queue #(.DEPTH(4), .PTR_W(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_pc     (in_pc),
        .in_inst   (in_inst),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_pc    (out_pc),
        .out_inst  (out_inst),
        .out_ready (out_ready),
        .count     (count)
    );

    // Free-running 10ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic applyStimulus(input logic r, input logic fl, input logic v,
                                 input logic [31:0] pc, input logic [31:0] inst,
                                 input logic ordy);
        rst       = r;
        flush     = fl;
        in_valid  = v;
        in_pc     = pc;
        in_inst   = inst;
        out_ready = ordy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Directed sequence of test steps
    initial begin
        total = 0;
        bad   = 0;
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        tick();
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);

        // Reset state
        checkOutput("rst_in_ready", {31'b0, in_ready}, 32'h1);
        checkOutput("rst_out_valid", {31'b0, out_valid}, 32'h0);
        checkOutput("rst_out_pc", out_pc, 32'h0);
        checkOutput("rst_out_inst", out_inst, 32'h0);
        checkOutput("rst_count", {29'b0, count}, 32'h0);

        // Fill with no consumer: PCs 0,4,8,C
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 32'(k * 4), 32'h100 + 32'(k), 1'b0);
            tick();
            checkOutput($sformatf("fill_count_%0d", k), {29'b0, count}, 32'(k + 1));
            checkOutput($sformatf("fill_head_%0d", k), out_pc, 32'h0);
        end
        checkOutput("full_in_ready", {31'b0, in_ready}, 32'h0);

        // Drain in order
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
            checkOutput($sformatf("drain_pc_%0d", k), out_pc, 32'(k * 4));
            checkOutput($sformatf("drain_inst_%0d", k), out_inst, 32'h100 + 32'(k));
            tick();
        end
        checkOutput("drained_count", {29'b0, count}, 32'h0);
        checkOutput("drained_out_valid", {31'b0, out_valid}, 32'h0);
        checkOutput("drained_out_pc", out_pc, 32'h0);

        // Refill to full, then offer a push while popping
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 32'h40 + 32'(k * 4), 32'h200 + 32'(k), 1'b0);
            tick();
        end
        checkOutput("refill_count", {29'b0, count}, 32'h4);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h50, 32'h204, 1'b1);
        checkOutput("full_pop_in_ready", {31'b0, in_ready}, 32'h0);
        tick();
        checkOutput("full_pop_count", {29'b0, count}, 32'h3);
        checkOutput("full_pop_in_ready_after", {31'b0, in_ready}, 32'h1);
        tick();
        checkOutput("push_pop_count", {29'b0, count}, 32'h3);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        checkOutput("after_full_head0", out_pc, 32'h48);
        tick();
        checkOutput("after_full_head1", out_pc, 32'h4C);
        tick();
        checkOutput("after_full_head2", out_pc, 32'h50);
        checkOutput("after_full_inst2", out_inst, 32'h204);
        tick();
        checkOutput("after_full_count", {29'b0, count}, 32'h0);

        // Streaming from empty: no pop in the first cycle, then a steady count of one
        for (int k = 0; k < 6; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 32'h1000 + 32'(k * 4), 32'h3000 + 32'(k), 1'b1);
            tick();
            checkOutput($sformatf("stream_count_%0d", k), {29'b0, count}, 32'h1);
            checkOutput($sformatf("stream_inst_%0d", k), out_inst, 32'h3000 + 32'(k));
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        tick();
        checkOutput("stream_end_count", {29'b0, count}, 32'h0);

        // Flush with concurrent push and pop
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 32'h2000 + 32'(k * 4), 32'h4000 + 32'(k), 1'b0);
            tick();
        end
        checkOutput("preflush_count", {29'b0, count}, 32'h3);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h2100, 32'h0000DEAD, 1'b1);
        checkOutput("flush_cycle_in_ready", {31'b0, in_ready}, 32'h1);
        checkOutput("flush_cycle_out_valid", {31'b0, out_valid}, 32'h1);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        checkOutput("flush_count", {29'b0, count}, 32'h0);
        checkOutput("flush_out_valid", {31'b0, out_valid}, 32'h0);
        checkOutput("flush_out_inst", out_inst, 32'h0);
        tick();
        checkOutput("flush_still_empty", {29'b0, count}, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h2200, 32'h5000, 1'b0);
        tick();
        checkOutput("postflush_inst", out_inst, 32'h5000);
        checkOutput("postflush_count", {29'b0, count}, 32'h1);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        tick();

        // Wrap-around: ten push/pop pairs
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 32'h3000 + 32'(k * 4), 32'h13 + 32'(k), 1'b0);
            tick();
            checkOutput($sformatf("wrap_inst_%0d", k), out_inst, 32'h13 + 32'(k));
            checkOutput($sformatf("wrap_pc_%0d", k), out_pc, 32'h3000 + 32'(k * 4));
            applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
            tick();
            checkOutput($sformatf("wrap_count_%0d", k), {29'b0, count}, 32'h0);
        end

        // Reset in the middle of traffic
        for (int k = 0; k < 2; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 32'h60 + 32'(k * 4), 32'h600 + 32'(k), 1'b0);
            tick();
        end
        checkOutput("prereset_count", {29'b0, count}, 32'h2);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h70, 32'h0000BEEF, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        checkOutput("midrst_count", {29'b0, count}, 32'h0);
        checkOutput("midrst_in_ready", {31'b0, in_ready}, 32'h1);
        checkOutput("midrst_out_valid", {31'b0, out_valid}, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h80, 32'h00100093, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        checkOutput("postrst_inst", out_inst, 32'h00100093);
        checkOutput("postrst_pc", out_pc, 32'h80);
        checkOutput("postrst_count", {29'b0, count}, 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/inst_prefetch_queue.md
INST_PREFETCH_QUEUE -- requirements
Module: inst_prefetch_queue

Parameters
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning the number of queue entries; legal values are powers of two from 2 to 16.
REQ-002 The block SHALL have parameter PTR_W, default 2, meaning the pointer width; PTR_W SHALL equal log2(DEPTH).

Interface
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset; synchronous, active-high.
REQ-005 The block SHALL have port flush, input, 1 bit: branch/jump redirect; discards all queued entries.
REQ-006 The block SHALL have port in_valid, input, 1 bit: the fetch stage offers an entry.
REQ-007 The block SHALL have port in_pc, input, 32 bits: PC of the offered instruction.
REQ-008 The block SHALL have port in_inst, input, 32 bits: the offered instruction word.
REQ-009 The block SHALL have port in_ready, output, 1 bit: the queue can accept an entry this cycle.
REQ-010 The block SHALL have port out_valid, output, 1 bit: the head entry is valid for decode.
REQ-011 The block SHALL have port out_pc, output, 32 bits: PC of the head entry.
REQ-012 The block SHALL have port out_inst, output, 32 bits: the head instruction word; decode takes opcode [6:0] and the immediate generator takes bits [31:7].
REQ-013 The block SHALL have port out_ready, input, 1 bit: decode consumes the head entry this cycle.
REQ-014 The block SHALL have port count, output, PTR_W+1 bits: the number of occupied entries, 0..DEPTH.

Function
REQ-015 A push SHALL occur when in_valid && in_ready && !flush; the entry is written at wr_ptr and wr_ptr advances by 1.
REQ-016 A pop SHALL occur when out_valid && out_ready && !flush; rd_ptr advances by 1.
REQ-017 Pointers SHALL be PTR_W bits and wrap from DEPTH-1 to 0 with no gap.
REQ-018 in_ready SHALL equal (count != DEPTH); it SHALL NOT depend on out_ready, so there is no combinational path from out_ready to in_ready.
REQ-019 out_valid SHALL equal (count != 0).
REQ-020 out_pc and out_inst SHALL be driven combinationally from the storage entry at rd_ptr, with no output register, giving 1-cycle push-to-visible latency.
REQ-021 When out_valid=0, out_pc and out_inst SHALL be 32'h0 rather than stale data.
REQ-022 count SHALL update as follows: push only gives +1; pop only gives -1; push and pop together leave count unchanged; neither leaves count unchanged.
REQ-023 Simultaneous push and pop with count=1 SHALL leave count=1, with the new entry at the head on the next cycle.
REQ-024 When full (count=DEPTH), in_ready SHALL be 0 even if out_ready=1 in the same cycle; the entry is accepted on the following cycle.
REQ-025 A push SHALL NOT be accepted when empty and popped in the same cycle; there is no bypass path.
REQ-026 Flush SHALL, on the next edge, set wr_ptr=0, rd_ptr=0 and count=0, dominating any concurrent push or pop.
REQ-027 During a flush cycle, in_ready and out_valid SHALL still reflect the pre-flush count, but no handshake completes.
REQ-028 Storage contents SHALL NOT require clearing on flush or reset; the valid state is governed by count alone.
REQ-029 Pop while empty and push while full SHALL be impossible by construction and SHALL NOT corrupt pointers.

Reset
REQ-030 When rst=1 at a rising edge, the block SHALL set wr_ptr=0, rd_ptr=0 and count=0.
REQ-031 After reset, the outputs SHALL be in_ready=1, out_valid=0, out_pc=32'h0, out_inst=32'h0 and count=0.
REQ-032 rst SHALL have priority over flush, push and pop.
REQ-033 Reset asserted mid-operation SHALL drop all queued entries; no handshake completes in that cycle.
REQ-034 The first push SHALL be accepted on the first edge after rst deasserts.

Verification
REQ-035 The bench SHALL cover fill then drain: push PCs 0x0,0x4,0x8,0xC with out_ready=0 -> count=4 and in_ready=0; then out_ready=1 -> out_pc sequence 0x0,0x4,0x8,0xC, followed by count=0 and out_valid=0.
REQ-036 The bench SHALL cover full with simultaneous pop: count=4, in_valid=1, out_ready=1 -> one pop, no push, count=3; next cycle the push is accepted and count stays 3.
REQ-037 The bench SHALL cover the streaming case: continuous in_valid=1 and out_ready=1 from empty -> count stays 1 after the first cycle and out_inst follows in_inst delayed by exactly 1 cycle.
REQ-038 The bench SHALL cover flush with concurrent traffic: count=3 with flush=1, in_valid=1, out_ready=1 -> next cycle count=0, out_valid=0, out_inst=32'h0, and the flushed-cycle entry is absent.
REQ-039 The bench SHALL cover wrap-around: run 10 push/pop pairs with inst=0x00000013+k -> the pointers wrap twice and the order is preserved exactly.
REQ-040 The bench SHALL cover reset mid-operation: count=2 with rst=1 for one cycle -> count=0 and in_ready=1; the next push of inst 0x00100093 appears at out_inst one cycle later.
